// File: rtl/inverse_park_and_clark_transaction_pkg.sv
// ----------------------------------------------------------------------------
// inverse_park_and_clark_transaction_pkg : shared widths, Q15 limits, FSM codes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package inverse_park_and_clark_transaction_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int ACC_WIDTH  = PROD_WIDTH + 1;
    localparam int FRAC_BITS  = DATA_WIDTH - 1;

    localparam logic signed [DATA_WIDTH-1:0] Q15_SAT_MAX    = 16'sh7fff;
    localparam logic signed [DATA_WIDTH-1:0] Q15_SAT_MIN    = 16'sh8000;
    localparam logic signed [DATA_WIDTH-1:0] SQRT3_DIV2_Q15 = 16'sd28378;

    localparam logic signed [ACC_WIDTH-1:0] ACC_SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, Q15_SAT_MAX};
    localparam logic signed [ACC_WIDTH-1:0] ACC_SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH){1'b1}}, Q15_SAT_MIN};

    localparam int STATE_WIDTH = 6;
    localparam logic [5:0] ST_IDLE    = 6'b000001;
    localparam logic [5:0] ST_ISSUE   = 6'b000010;
    localparam logic [5:0] ST_COLLECT = 6'b000100;
    localparam logic [5:0] ST_DONE    = 6'b001000;
    localparam logic [5:0] ST_CLARK1  = 6'b010000;
    localparam logic [5:0] ST_CLARK2  = 6'b100000;

    // Operand pair issued to the shared multiplier, in issue order
    typedef enum logic [1:0] {
        PAIR_VD_COS = 2'd0,
        PAIR_VQ_SIN = 2'd1,
        PAIR_VD_SIN = 2'd2,
        PAIR_VQ_COS = 2'd3
    } pair_e;

    function automatic logic signed [DATA_WIDTH-1:0] sat_q15(
        input logic signed [ACC_WIDTH-1:0] x
    );
        if (x > ACC_SAT_MAX) begin
            return Q15_SAT_MAX;
        end else if (x < ACC_SAT_MIN) begin
            return Q15_SAT_MIN;
        end else begin
            return x[DATA_WIDTH-1:0];
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/inverse_park_and_clark_transaction_mult.sv
// ----------------------------------------------------------------------------
// inverse_park_multiplier : signed 16x16 -> 32 multiplier, MULT_LATENCY stages
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module inverse_park_multiplier
    import inverse_park_and_clark_transaction_pkg::*;
#(
    parameter int MULT_LATENCY = 3
) (
    input  logic                         sys_clk,
    input  logic                         reset_n,
    input  logic signed [DATA_WIDTH-1:0] operand_a_i,
    input  logic signed [DATA_WIDTH-1:0] operand_b_i,
    output logic signed [PROD_WIDTH-1:0] product_o
);

    logic signed [PROD_WIDTH-1:0] product_d;
    logic signed [PROD_WIDTH-1:0] stage_q [MULT_LATENCY];

    assign product_d = operand_a_i * operand_b_i;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MULT_LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= product_d;
            for (int i = 1; i < MULT_LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign product_o = stage_q[MULT_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/inverse_park_and_clark_transaction.sv
// ----------------------------------------------------------------------------
// inverse_park_and_clark_transaction : dq -> alpha/beta via one shared multiplier;
// optional inverse Clark (three-phase) stage when INV_CLARK_EN is defined. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module inverse_park_and_clark_transaction
    import inverse_park_and_clark_transaction_pkg::*;
#(
    parameter int MULT_LATENCY = 3
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic                  transaction_enable_in,
    input  logic [DATA_WIDTH-1:0] voltage_d_in,
    input  logic [DATA_WIDTH-1:0] voltage_q_in,
    input  logic [DATA_WIDTH-1:0] electrical_rotation_phase_sin_in,
    input  logic [DATA_WIDTH-1:0] electrical_rotation_phase_cos_in,
    output logic [DATA_WIDTH-1:0] voltage_alpha_out,
    output logic [DATA_WIDTH-1:0] voltage_beta_out,
`ifdef INV_CLARK_EN
    output logic [DATA_WIDTH-1:0] phase_a_voltage_out,
    output logic [DATA_WIDTH-1:0] phase_b_voltage_out,
    output logic [DATA_WIDTH-1:0] phase_c_voltage_out,
`endif
    output logic                  busy_out,
    output logic                  transaction_valid_out
);

    logic [STATE_WIDTH-1:0]       state_q, state_d;
    logic [2:0]                   cnt_q, cnt_d;
    logic                         capture;
    logic signed [DATA_WIDTH-1:0] vd_q, vq_q, sin_q, cos_q;
    logic signed [DATA_WIDTH-1:0] mult_a, mult_b;
    logic                         issue_vld;
    pair_e                        issue_idx;
    logic signed [PROD_WIDTH-1:0] product;
    logic                         tag_vld_q [MULT_LATENCY];
    pair_e                        tag_idx_q [MULT_LATENCY];
    logic signed [ACC_WIDTH-1:0]  product_ext;
    logic signed [ACC_WIDTH-1:0]  acc_alpha_q, acc_alpha_d;
    logic signed [ACC_WIDTH-1:0]  acc_beta_q, acc_beta_d;
    logic signed [DATA_WIDTH-1:0] alpha_q, alpha_d;
    logic signed [DATA_WIDTH-1:0] beta_q, beta_d;
    logic                         valid_q, valid_d;

    assign capture = (state_q == ST_IDLE) && transaction_enable_in;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        issue_vld = 1'b0;
        issue_idx = pair_e'(cnt_q[1:0]);
        mult_a    = '0;
        mult_b    = '0;
        case (state_q)
            ST_IDLE: begin
                if (transaction_enable_in) begin
                    state_d = ST_ISSUE;
                    cnt_d   = '0;
                end
            end
            ST_ISSUE: begin
                issue_vld = 1'b1;
                case (issue_idx)
                    PAIR_VD_COS: begin mult_a = vd_q; mult_b = cos_q; end
                    PAIR_VQ_SIN: begin mult_a = vq_q; mult_b = sin_q; end
                    PAIR_VD_SIN: begin mult_a = vd_q; mult_b = sin_q; end
                    PAIR_VQ_COS: begin mult_a = vq_q; mult_b = cos_q; end
                endcase
                if (cnt_q == 3'd3) begin
                    state_d = ST_COLLECT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            // The last product is accumulated one cycle before the final COLLECT cycle ends
            ST_COLLECT: begin
                if (cnt_q == 3'(MULT_LATENCY)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_DONE: begin
`ifdef INV_CLARK_EN
                state_d = ST_CLARK1;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef INV_CLARK_EN
            ST_CLARK1: state_d = ST_CLARK2;
            ST_CLARK2: state_d = ST_IDLE;
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    inverse_park_multiplier #(
        .MULT_LATENCY (MULT_LATENCY)
    ) u_mult (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .operand_a_i (mult_a),
        .operand_b_i (mult_b),
        .product_o   (product)
    );

    // Tags travel alongside the multiplier pipeline to identify each emerging product
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MULT_LATENCY; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_idx_q[i] <= PAIR_VD_COS;
            end
        end else begin
            tag_vld_q[0] <= issue_vld;
            tag_idx_q[0] <= issue_idx;
            for (int i = 1; i < MULT_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
        end
    end

    assign product_ext = {product[PROD_WIDTH-1], product};

    always_comb begin
        acc_alpha_d = acc_alpha_q;
        acc_beta_d  = acc_beta_q;
        if (tag_vld_q[MULT_LATENCY-1]) begin
            case (tag_idx_q[MULT_LATENCY-1])
                PAIR_VD_COS: acc_alpha_d = product_ext;
                PAIR_VQ_SIN: acc_alpha_d = acc_alpha_q - product_ext;
                PAIR_VD_SIN: acc_beta_d  = product_ext;
                PAIR_VQ_COS: acc_beta_d  = acc_beta_q + product_ext;
            endcase
        end
    end

    always_comb begin
        alpha_d = alpha_q;
        beta_d  = beta_q;
        if (state_q == ST_DONE) begin
            alpha_d = sat_q15(acc_alpha_q >>> FRAC_BITS);
            beta_d  = sat_q15(acc_beta_q >>> FRAC_BITS);
        end
`ifdef INV_CLARK_EN
        valid_d = (state_q == ST_CLARK2);
`else
        valid_d = (state_q == ST_DONE);
`endif
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            vd_q        <= '0;
            vq_q        <= '0;
            sin_q       <= '0;
            cos_q       <= '0;
            acc_alpha_q <= '0;
            acc_beta_q  <= '0;
            alpha_q     <= '0;
            beta_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (capture) begin
                vd_q  <= voltage_d_in;
                vq_q  <= voltage_q_in;
                sin_q <= electrical_rotation_phase_sin_in;
                cos_q <= electrical_rotation_phase_cos_in;
            end
            acc_alpha_q <= acc_alpha_d;
            acc_beta_q  <= acc_beta_d;
            alpha_q     <= alpha_d;
            beta_q      <= beta_d;
            valid_q     <= valid_d;
        end
    end

`ifdef INV_CLARK_EN
    logic signed [PROD_WIDTH-1:0] k_prod;
    logic signed [DATA_WIDTH:0]   neg_alpha;
    logic signed [DATA_WIDTH:0]   h_q, h_d;
    logic signed [DATA_WIDTH-1:0] k_q, k_d;
    logic signed [DATA_WIDTH+1:0] vb_sum, vc_sum;
    logic signed [DATA_WIDTH-1:0] pa_q, pa_d, pb_q, pb_d, pc_q, pc_d;

    // Negate before halving at 17 bits so -32768 is representable; h is floor(-alpha/2)
    assign neg_alpha = -{alpha_q[DATA_WIDTH-1], alpha_q};
    assign k_prod    = beta_q * SQRT3_DIV2_Q15;
    assign vb_sum    = {h_q[DATA_WIDTH], h_q} + {{2{k_q[DATA_WIDTH-1]}}, k_q};
    assign vc_sum    = {h_q[DATA_WIDTH], h_q} - {{2{k_q[DATA_WIDTH-1]}}, k_q};

    always_comb begin
        h_d  = h_q;
        k_d  = k_q;
        pa_d = pa_q;
        pb_d = pb_q;
        pc_d = pc_q;
        if (state_q == ST_CLARK1) begin
            h_d = neg_alpha >>> 1;
            k_d = k_prod[PROD_WIDTH-2:FRAC_BITS];
        end
        if (state_q == ST_CLARK2) begin
            pa_d = alpha_q;
            pb_d = sat_q15({{(ACC_WIDTH-DATA_WIDTH-2){vb_sum[DATA_WIDTH+1]}}, vb_sum});
            pc_d = sat_q15({{(ACC_WIDTH-DATA_WIDTH-2){vc_sum[DATA_WIDTH+1]}}, vc_sum});
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q  <= '0;
            k_q  <= '0;
            pa_q <= '0;
            pb_q <= '0;
            pc_q <= '0;
        end else begin
            h_q  <= h_d;
            k_q  <= k_d;
            pa_q <= pa_d;
            pb_q <= pb_d;
            pc_q <= pc_d;
        end
    end

    assign phase_a_voltage_out = pa_q;
    assign phase_b_voltage_out = pb_q;
    assign phase_c_voltage_out = pc_q;
`endif

    assign voltage_alpha_out     = alpha_q;
    assign voltage_beta_out      = beta_q;
    assign busy_out              = (state_q != ST_IDLE);
    assign transaction_valid_out = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_inverse_park_and_clark_transaction.sv
// ----------------------------------------------------------------------------
// tb_inverse_park_and_clark_transaction : directed + random checks against a
// plain-arithmetic inverse Park / Clark model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_inverse_park_and_clark_transaction;

    localparam int ML = 3;
`ifdef INV_CLARK_EN
    localparam int LAT = ML + 8;
`else
    localparam int LAT = ML + 6;
`endif

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en      = 1'b0;
    logic [15:0] vd_in = '0, vq_in = '0, sin_in = '0, cos_in = '0;
    logic [15:0] alpha_o, beta_o;
    logic [15:0] pa_o, pb_o, pc_o;
    logic        busy_o, valid_o;

    int n_checks = 0;
    int n_errors = 0;

    inverse_park_and_clark_transaction #(
        .MULT_LATENCY (ML)
    ) dut (
        .sys_clk                          (sys_clk),
        .reset_n                          (reset_n),
        .transaction_enable_in            (en),
        .voltage_d_in                     (vd_in),
        .voltage_q_in                     (vq_in),
        .electrical_rotation_phase_sin_in (sin_in),
        .electrical_rotation_phase_cos_in (cos_in),
        .voltage_alpha_out                (alpha_o),
        .voltage_beta_out                 (beta_o),
`ifdef INV_CLARK_EN
        .phase_a_voltage_out              (pa_o),
        .phase_b_voltage_out              (pb_o),
        .phase_c_voltage_out              (pc_o),
`endif
        .busy_out                         (busy_o),
        .transaction_valid_out            (valid_o)
    );

`ifndef INV_CLARK_EN
    assign pa_o = '0;
    assign pb_o = '0;
    assign pc_o = '0;
`endif

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int ref_sat(input longint x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return int'(x);
    endfunction

    // Reference: real-valued formulas evaluated in wide integers, floor division by 2^15
    function automatic void ref_model(input int vd, input int vq, input int s, input int c,
                                      output int alpha, output int beta,
                                      output int pa, output int pb, output int pc);
        longint h, k;
        alpha = ref_sat((longint'(vd) * c - longint'(vq) * s) >>> 15);
        beta  = ref_sat((longint'(vd) * s + longint'(vq) * c) >>> 15);
        h     = (-longint'(alpha)) >>> 1;
        k     = (longint'(beta) * 28378) >>> 15;
        pa    = alpha;
        pb    = ref_sat(h + k);
        pc    = ref_sat(h - k);
    endfunction

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic check_outputs(input string tag, input int vd, input int vq,
                                 input int s, input int c);
        int a, b, pa, pb, pc;
        ref_model(vd, vq, s, c, a, b, pa, pb, pc);
        check_value({tag, "_alpha"}, s16(alpha_o), a);
        check_value({tag, "_beta"},  s16(beta_o),  b);
`ifdef INV_CLARK_EN
        check_value({tag, "_va"}, s16(pa_o), pa);
        check_value({tag, "_vb"}, s16(pb_o), pb);
        check_value({tag, "_vc"}, s16(pc_o), pc);
`endif
    endtask

    task automatic drive(input int vd, input int vq, input int s, input int c);
        vd_in  = 16'(vd);
        vq_in  = 16'(vq);
        sin_in = 16'(s);
        cos_in = 16'(c);
    endtask

    task automatic run_txn(input string tag, input int vd, input int vq,
                           input int s, input int c);
        int lat;
        @(negedge sys_clk);
        drive(vd, vq, s, c);
        en = 1'b1;
        @(posedge sys_clk);
        #1;
        en = 1'b0;
        drive(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
        check_value({tag, "_busy"}, int'(busy_o), 1);
        lat = 0;
        for (int n = 1; n <= LAT + 10; n++) begin
            @(posedge sys_clk);
            #1;
            if (valid_o) begin
                lat = n;
                break;
            end
        end
        check_value({tag, "_latency"}, lat, LAT);
        check_outputs(tag, vd, vq, s, c);
        @(posedge sys_clk);
        #1;
        check_value({tag, "_valid_pulse"}, int'(valid_o), 0);
        check_value({tag, "_idle"}, int'(busy_o), 0);
    endtask

    function automatic int rand_q15();
        case ($urandom_range(0, 5))
            0:       return 32767;
            1:       return -32768;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    initial begin
        int a1, b1, c1, d1, a2, b2, c2, d2;
        int vcount, saw_valid;

        repeat (3) @(posedge sys_clk);
        #1;
        check_value("rst_alpha", s16(alpha_o), 0);
        check_value("rst_beta",  s16(beta_o),  0);
        check_value("rst_busy",  int'(busy_o), 0);
        check_value("rst_valid", int'(valid_o), 0);
        @(negedge sys_clk);
        reset_n = 1'b1;

        run_txn("theta0", 16384, 0, 0, 32767);
        check_value("theta0_alpha_const", s16(alpha_o), 16383);
        check_value("theta0_beta_const",  s16(beta_o),  0);
`ifdef INV_CLARK_EN
        check_value("theta0_vb_const", s16(pb_o), -8192);
        check_value("theta0_vc_const", s16(pc_o), -8192);
`endif
        run_txn("theta90", 0, 16384, 32767, 0);
        check_value("theta90_alpha_const", s16(alpha_o), -16384);
        run_txn("sat", 32767, -32768, 32767, 32767);
        check_value("sat_alpha_const", s16(alpha_o), 32767);
        check_value("sat_beta_const",  s16(beta_o),  -1);
`ifdef INV_CLARK_EN
        run_txn("clark_beta", 0, 16385, 0, 32767);
        check_value("clark_beta_vb_const", s16(pb_o), 14189);
        check_value("clark_beta_vc_const", s16(pc_o), -14189);
`endif

        // Enable held high: first capture at edge 0, second in the valid cycle
        a1 = rand_q15(); b1 = rand_q15(); c1 = rand_q15(); d1 = rand_q15();
        a2 = rand_q15(); b2 = rand_q15(); c2 = rand_q15(); d2 = rand_q15();
        @(negedge sys_clk);
        drive(a1, b1, c1, d1);
        en = 1'b1;
        @(posedge sys_clk);
        #1;
        drive(a2, b2, c2, d2);
        vcount = 0;
        for (int n = 1; n <= 2 * LAT + 12; n++) begin
            @(posedge sys_clk);
            #1;
            if (n == 5) check_value("hold_busy", int'(busy_o), 1);
            if (n == LAT + 1) drive(rand_q15(), rand_q15(), rand_q15(), rand_q15());
            if (n == 19) en = 1'b0;
            if (valid_o) begin
                vcount++;
                if (vcount == 1) begin
                    check_value("hold_v1_edge", n, LAT);
                    check_outputs("hold_v1", a1, b1, c1, d1);
                end else if (vcount == 2) begin
                    check_value("hold_v2_edge", n, 2 * LAT + 1);
                    check_outputs("hold_v2", a2, b2, c2, d2);
                end
            end
        end
        en = 1'b0;
        check_value("hold_valid_count", vcount, 2);

        // Reset in the middle of a transaction
        run_txn("pre_rst", 20000, -12000, 23170, 23170);
        @(negedge sys_clk);
        drive(-9000, 31000, -5000, 30000);
        en = 1'b1;
        @(posedge sys_clk);
        #1;
        en = 1'b0;
        repeat (5) @(posedge sys_clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_value("midrst_alpha", s16(alpha_o), 0);
        check_value("midrst_beta",  s16(beta_o),  0);
        check_value("midrst_busy",  int'(busy_o), 0);
        check_value("midrst_valid", int'(valid_o), 0);
`ifdef INV_CLARK_EN
        check_value("midrst_va", s16(pa_o), 0);
`endif
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;
        saw_valid = 0;
        for (int n = 0; n < LAT + 8; n++) begin
            @(posedge sys_clk);
            #1;
            if (valid_o) saw_valid = 1;
        end
        check_value("midrst_no_valid", saw_valid, 0);
        run_txn("post_rst", -9000, 31000, -5000, 30000);

        for (int i = 0; i < 16; i++) begin
            run_txn($sformatf("rand%0d", i), rand_q15(), rand_q15(), rand_q15(), rand_q15());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
